// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder slice.
// Latency and backpressure are properties of dmem_responder; this package only holds the types.
package dmem_pkg;

    localparam int WORD_W     = 32;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic              write;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core memory stage (master) and the responder (slave).
// Both channels are valid/ready; the bundle itself holds no state.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM, contents not reset.
// Latency: read data registered, valid one cycle after addr; no backpressure.
module dmem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store in flight, WAIT_CYCLES wait states, optional DMEM_ERR_EN checks.
// Latency: accept at edge N -> response sampled at edge N+1+WAIT_CYCLES; response held until rsp_ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    if (WAIT_CYCLES > (2**WAIT_CNT_W) - 1 || WAIT_CYCLES < 0) begin : g_bad_cfg
        $fatal(1, "dmem_responder: WAIT_CYCLES out of range 0..15");
    end

    localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [WAIT_CNT_W-1:0] cnt;
    logic                  req_ready_q;
    req_t                  req_q;
    req_t                  cur;
    logic                  hs_req;
    logic                  access;
    logic                  cur_err;
    logic                  ram_we;
    logic [WORD_W-1:0]     ram_rdata;

    assign hs_req = bus.req_valid && req_ready_q;

    // With zero wait states the access happens on the accept edge, so the RAM sees the live request.
    assign cur = (state == IDLE) ? '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata}
                                 : req_q;

    assign access = ((state == IDLE) && hs_req && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (cnt == '0));

`ifdef DMEM_ERR_EN
    assign cur_err = (cur.addr[1:0] != 2'b00) || (cur.addr[WORD_W-1:ADDR_W+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cur.addr[1:0], cur.addr[WORD_W-1:ADDR_W+2]};
    assign cur_err          = 1'b0;
`endif

    assign ram_we = access && cur.write && !cur_err;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (cur.addr[ADDR_W+1:2]),
        .wdata (cur.wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs_req) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            req_ready_q <= 1'b0;
            req_q       <= '0;
        end else begin
            req_ready_q <= (state_nxt == IDLE);
            if ((state == IDLE) && hs_req) begin
                req_q <= cur;
                cnt   <= CNT_INIT;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // RAM address stays on req_q during RESP, so the registered read data holds under backpressure.
    always_comb begin
        bus.req_ready = req_ready_q;
        bus.rsp_valid = (state == RESP);
        bus.rsp_err   = (state == RESP) && cur_err;
        bus.rsp_rdata = '0;
        if ((state == RESP) && !req_q.write && !cur_err) begin
            bus.rsp_rdata = ram_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus randomized traffic against a word-array model.
// Runs a WAIT_CYCLES=2 instance and a back-to-back WAIT_CYCLES=0 instance; honours DMEM_ERR_EN.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int W_M    = 2;
    localparam int ADDR_W = 10;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    logic [31:0] mem_m [int];
    logic [31:0] mem_z [int];

    dmem_responder_if m_if ();
    dmem_responder_if z_if ();

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W_M)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if.slave)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (z_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic err_of(input logic [31:0] a);
`ifdef DMEM_ERR_EN
        return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[ADDR_W+1:2]);
    endfunction

    // Model: expected response for one access, then apply it to the word array.
    task automatic model_m(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] exp_d, output logic exp_e);
        exp_e = err_of(a);
        exp_d = 32'h0;
        if (!wr && !exp_e) exp_d = mem_m.exists(idx_of(a)) ? mem_m[idx_of(a)] : 32'hx;
        if (wr && !exp_e) mem_m[idx_of(a)] = wd;
    endtask

    task automatic model_z(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] exp_d, output logic exp_e);
        exp_e = err_of(a);
        exp_d = 32'h0;
        if (!wr && !exp_e) exp_d = mem_z.exists(idx_of(a)) ? mem_z[idx_of(a)] : 32'hx;
        if (wr && !exp_e) mem_z[idx_of(a)] = wd;
    endtask

    task automatic wait_ready_m();
        int k;
        k = 0;
        while (!m_if.req_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_wait", 32'(m_if.req_ready), 32'h1);
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance with bp cycles of response backpressure.
    task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int bp);
        logic [31:0] exp_d;
        logic        exp_e;
        int          k;
        model_m(wr, a, wd, exp_d, exp_e);
        m_if.rsp_ready = (bp == 0);
        wait_ready_m();
        m_if.req_valid = 1'b1;
        m_if.req_write = wr;
        m_if.req_addr  = a;
        m_if.req_wdata = wd;
        @(posedge clk);
        #1;
        m_if.req_valid = 1'b0;
        m_if.req_write = 1'($urandom);
        m_if.req_addr  = $urandom;
        m_if.req_wdata = $urandom;
        chk("req_ready_after_accept", 32'(m_if.req_ready), 32'h0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!m_if.rsp_valid && k < 40);
        chk("rsp_latency", 32'(k), 32'(1 + W_M));
        chk("rsp_rdata", m_if.rsp_rdata, exp_d);
        chk("rsp_err", 32'(m_if.rsp_err), 32'(exp_e));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(m_if.rsp_valid), 32'h1);
            chk("bp_rsp_rdata", m_if.rsp_rdata, exp_d);
            chk("bp_req_ready", 32'(m_if.req_ready), 32'h0);
        end
        m_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_rsp_valid", 32'(m_if.rsp_valid), 32'h0);
        chk("post_hs_rsp_rdata", m_if.rsp_rdata, 32'h0);
        chk("post_hs_req_ready", 32'(m_if.req_ready), 32'h1);
    endtask

    function automatic logic [31:0] rand_addr(input int idx);
        logic [19:0] up;
        logic [1:0]  lo;
        up = ($urandom_range(0, 4) == 0) ? 20'($urandom_range(1, 20'hFFFFF)) : 20'h0;
        lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return {up, 10'(idx), lo};
    endfunction

    initial begin
        req_t        zq[$];
        logic [31:0] exp_d;
        logic        exp_e;
        int          pool[8];

        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        m_if.req_valid = 1'b0; m_if.req_write = 1'b0; m_if.req_addr = '0;
        m_if.req_wdata = '0;   m_if.rsp_ready = 1'b0;
        z_if.req_valid = 1'b0; z_if.req_write = 1'b0; z_if.req_addr = '0;
        z_if.req_wdata = '0;   z_if.rsp_ready = 1'b1;

        // Reset state and release timing
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(m_if.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(m_if.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", m_if.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(m_if.rsp_err), 32'h0);
        chk("rst_z_req_ready", 32'(z_if.req_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("release_no_edge_ready", 32'(m_if.req_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("release_one_edge_ready", 32'(m_if.req_ready), 32'h1);

        // Store then load, then a held-off load
        xact(1'b1, 32'h10, 32'hDEADBEEF, 0);
        xact(1'b0, 32'h10, 32'h0, 0);
        xact(1'b0, 32'h10, 32'h0, 5);

        // Reset during WAIT of a store: the store must never land
        xact(1'b1, 32'h20, 32'hAAAA5555, 0);
        wait_ready_m();
        m_if.req_valid = 1'b1; m_if.req_write = 1'b1;
        m_if.req_addr  = 32'h20; m_if.req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        m_if.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(m_if.req_ready), 32'h0);
        chk("midrst_rsp_valid", 32'(m_if.rsp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready_back", 32'(m_if.req_ready), 32'h1);
        xact(1'b0, 32'h20, 32'h0, 0);

        // Misaligned and out-of-range addresses
        xact(1'b0, 32'h13, 32'h0, 1);
        xact(1'b1, 32'h11, 32'hCAFEF00D, 0);
        xact(1'b0, 32'h10, 32'h0, 0);
        xact(1'b0, 32'h0001_0020, 32'h0, 0);

        // Randomized traffic over a small pool of initialized words
        for (int i = 0; i < 8; i++) begin
            pool[i] = (i * 37 + 3) % (2**ADDR_W);
            xact(1'b1, {20'h0, 10'(pool[i]), 2'b00}, $urandom, 0);
        end
        for (int i = 0; i < 40; i++) begin
            xact(1'($urandom), rand_addr(pool[$urandom_range(0, 7)]), $urandom,
                 $urandom_range(0, 3));
        end

        // Zero-wait instance: back-to-back requests, one response every two cycles
        for (int i = 0; i < 8; i++) zq.push_back('{write: 1'b1, addr: {20'h0, 10'(pool[i]), 2'b00}, wdata: $urandom});
        for (int i = 0; i < 16; i++) zq.push_back('{write: 1'($urandom), addr: rand_addr(pool[$urandom_range(0, 7)]), wdata: $urandom});
        @(negedge clk);
        chk("z_req_ready_start", 32'(z_if.req_ready), 32'h1);
        z_if.req_valid = 1'b1;
        z_if.req_write = zq[0].write; z_if.req_addr = zq[0].addr; z_if.req_wdata = zq[0].wdata;
        for (int i = 0; i < zq.size(); i++) begin
            @(posedge clk);
            @(negedge clk);
            model_z(zq[i].write, zq[i].addr, zq[i].wdata, exp_d, exp_e);
            chk("z_rsp_valid", 32'(z_if.rsp_valid), 32'h1);
            chk("z_rsp_rdata", z_if.rsp_rdata, exp_d);
            chk("z_rsp_err", 32'(z_if.rsp_err), 32'(exp_e));
            chk("z_req_ready_busy", 32'(z_if.req_ready), 32'h0);
            if (i + 1 < zq.size()) begin
                z_if.req_write = zq[i+1].write; z_if.req_addr = zq[i+1].addr;
                z_if.req_wdata = zq[i+1].wdata;
            end else begin
                z_if.req_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            chk("z_rsp_valid_gap", 32'(z_if.rsp_valid), 32'h0);
            chk("z_req_ready_gap", 32'(z_if.req_ready), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
